wb_trace_checker: RTL and testbench

Synthesizable writeback-trace checker that consumes a stream of golden trace entries (commit flag, pc, register number, write data) and compares them, in order, against the core's debug writeback port. It sits beside the CPU in the SoC top and lets FPGA runs perform the same golden-trace comparison the simulation bench does, latching the first mismatch for readout through confreg or an ILA. Golden entries arrive over a valid/ready stream from a loader (BRAM or UART) and are buffered in a small FIFO, because the writeback port cannot be stalled.

---
 rtl/wb_trace_checker.sv | 80 ++++++++
 tb/tb_wb_trace_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker.sv
// wb_trace_checker: checks core writebacks in order against a buffered golden trace and latches the first mismatch
module wb_trace_checker #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] END_PC     = 32'hbfc00100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        trace_en,
  input  logic        ref_valid,
  output logic        ref_ready,
  input  logic        ref_cmp,
  input  logic [31:0] ref_pc,
  input  logic [4:0]  ref_wnum,
  input  logic [31:0] ref_wdata,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_wen,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  output logic        err,
  output logic        underflow,
  output logic        done,
  output logic [31:0] err_pc,
  output logic [31:0] err_wdata,
  output logic [31:0] err_ref_wdata,
  output logic [31:0] cmp_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {RUN, ERR, DONE} state_t;
  state_t state;
  logic [68:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] head_pc, head_wdata, mask;
  logic [4:0] head_wnum;
  logic empty, full, push, pop, wb_event, match, fail, end_hit;
  assign {head_pc, head_wnum, head_wdata} = mem[rd_ptr[AW-1:0]];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign ref_ready = (state == RUN) && !full;
  assign push = ref_valid && ref_ready && ref_cmp;
  assign wb_event = (state == RUN) && trace_en && |debug_wb_rf_wen && debug_wb_rf_wnum != 5'd0;
  assign pop = wb_event && !empty;
  assign mask = {{8{debug_wb_rf_wen[3]}}, {8{debug_wb_rf_wen[2]}}, {8{debug_wb_rf_wen[1]}}, {8{debug_wb_rf_wen[0]}}};
  assign match = head_pc == debug_wb_pc && head_wnum == debug_wb_rf_wnum &&
                 (head_wdata & mask) == (debug_wb_rf_wdata & mask);
  assign fail = wb_event && (empty || !match);
  assign end_hit = (state == RUN) && debug_wb_pc == END_PC;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {ref_pc, ref_wnum, ref_wdata};
  // a failing compare wins over END_PC in the same cycle, so done never rises alongside err
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      err           <= 1'b0;
      underflow     <= 1'b0;
      done          <= 1'b0;
      err_pc        <= '0;
      err_wdata     <= '0;
      err_ref_wdata <= '0;
      cmp_count     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (fail) begin
        state         <= ERR;
        err           <= 1'b1;
        underflow     <= empty;
        err_pc        <= debug_wb_pc;
        err_wdata     <= debug_wb_rf_wdata & mask;
        err_ref_wdata <= empty ? 32'd0 : head_wdata & mask;
      end else begin
        if (pop) cmp_count <= cmp_count + {31'd0, cmp_count != '1};
        if (end_hit) begin
          state <= DONE;
          done  <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: directed scoreboard bench for wb_trace_checker
module tb_wb_trace_checker;
  localparam int D = 16;
  localparam logic [31:0] END_PC = 32'hbfc00100;
  logic clk = 0, resetn = 0, trace_en = 0, ref_valid = 0, ref_cmp = 0;
  logic [31:0] ref_pc = 0, ref_wdata = 0, debug_wb_pc = 0, debug_wb_rf_wdata = 0;
  logic [4:0] ref_wnum = 0, debug_wb_rf_wnum = 0;
  logic [3:0] debug_wb_rf_wen = 0;
  logic ref_ready, err, underflow, done;
  logic [31:0] err_pc, err_wdata, err_ref_wdata, cmp_count;
  always #5 clk = ~clk;
  wb_trace_checker #(.FIFO_DEPTH(D), .END_PC(END_PC)) dut (
    .clk(clk), .resetn(resetn), .trace_en(trace_en), .ref_valid(ref_valid), .ref_ready(ref_ready),
    .ref_cmp(ref_cmp), .ref_pc(ref_pc), .ref_wnum(ref_wnum), .ref_wdata(ref_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .err(err), .underflow(underflow), .done(done),
    .err_pc(err_pc), .err_wdata(err_wdata), .err_ref_wdata(err_ref_wdata), .cmp_count(cmp_count)
  );
  typedef struct packed {logic [31:0] pc; logic [4:0] n; logic [31:0] d;} ent_t;
  ent_t sb[$];
  int total = 0, bad = 0;
  logic [1:0] e_st;
  logic e_err, e_uf, e_done;
  logic [31:0] e_epc, e_ewd, e_erwd, e_cnt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    sb.delete();
    e_st = 0; e_err = 0; e_uf = 0; e_done = 0;
    e_epc = 0; e_ewd = 0; e_erwd = 0; e_cnt = 0;
  endtask
  task automatic check_outs();
    chk("ref_ready", {31'd0, ref_ready}, {31'd0, e_st == 0 && sb.size() < D});
    chk("err", {31'd0, err}, {31'd0, e_err});
    chk("underflow", {31'd0, underflow}, {31'd0, e_uf});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("err_pc", err_pc, e_epc);
    chk("err_wdata", err_wdata, e_ewd);
    chk("err_ref_wdata", err_ref_wdata, e_erwd);
    chk("cmp_count", cmp_count, e_cnt);
  endtask
  task automatic model_wb(input logic te, input logic [31:0] pc, input logic [3:0] wen,
                          input logic [4:0] wn, input logic [31:0] wd);
    logic [31:0] m;
    logic fl;
    ent_t g;
    if (e_st != 0) return;
    m = 0;
    for (int i = 0; i < 4; i++) if (wen[i]) m[i*8 +: 8] = 8'hff;
    fl = 0;
    if (te && wen != 0 && wn != 0) begin
      if (sb.size() == 0) begin
        fl = 1; e_uf = 1; e_epc = pc; e_ewd = wd & m; e_erwd = 0;
      end else begin
        g = sb.pop_front();
        if (g.pc == pc && g.n == wn && (g.d & m) == (wd & m)) e_cnt++;
        else begin
          fl = 1; e_epc = pc; e_ewd = wd & m; e_erwd = g.d & m;
        end
      end
    end
    if (fl) begin e_st = 1; e_err = 1; end
    else if (pc == END_PC) begin e_st = 2; e_done = 1; end
  endtask
  task automatic cyc(input logic rv, input logic rc, input logic [31:0] rpc, input logic [4:0] rn,
                     input logic [31:0] rd, input logic te, input logic [31:0] pc, input logic [3:0] wen,
                     input logic [4:0] wn, input logic [31:0] wd);
    logic acc;
    ref_valid = rv; ref_cmp = rc; ref_pc = rpc; ref_wnum = rn; ref_wdata = rd;
    trace_en = te; debug_wb_pc = pc; debug_wb_rf_wen = wen; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
    #1;
    acc = rv && rc && e_st == 0 && sb.size() < D;
    chk("ready_pre", {31'd0, ref_ready}, {31'd0, e_st == 0 && sb.size() < D});
    model_wb(te, pc, wen, wn, wd);
    if (acc) sb.push_back('{pc: rpc, n: rn, d: rd});
    @(posedge clk);
    #1;
    ref_valid = 0; trace_en = 0; debug_wb_pc = 0; debug_wb_rf_wen = 0;
    check_outs();
  endtask
  task automatic ref_push(input logic c, input logic [31:0] pc, input logic [4:0] n, input logic [31:0] d);
    cyc(1, c, pc, n, d, 0, 0, 0, 0, 0);
  endtask
  task automatic ev(input logic te, input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] n,
                    input logic [31:0] d);
    cyc(0, 0, 0, 0, 0, te, pc, wen, n, d);
  endtask
  task automatic do_reset();
    #3 resetn = 0;
    #1;
    model_clear();
    check_outs();
    @(posedge clk);
    #1 resetn = 1;
  endtask
  function automatic logic [31:0] fpc(int k); return 32'h1000 + 32'(4 * k); endfunction
  function automatic logic [31:0] fd(int k); return 32'h9e3779b9 * 32'(k + 1); endfunction
  function automatic logic [4:0] fn(int k); return 5'(1 + k % 31); endfunction
  initial begin
    model_clear();
    #1;
    check_outs();
    @(posedge clk);
    #1 resetn = 1;
    for (int k = 0; k < 3; k++) ref_push(1, 32'hbfc00000 + 32'(4 * k), 1, 32'h11 * 32'(k + 1));
    for (int k = 0; k < 3; k++) ev(1, 32'hbfc00000 + 32'(4 * k), 4'hf, 1, 32'h11 * 32'(k + 1));
    chk("match_cnt", cmp_count, 3);
    chk("match_err", {31'd0, err}, 0);
    ref_push(1, 32'hbfc00010, 2, 32'haabbccdd);
    ev(1, 32'hbfc00010, 4'b0111, 2, 32'h00bbccdd);
    chk("mask_cnt", cmp_count, 4);
    ref_push(0, 32'hdead0000, 7, 32'hdeadbeef);
    ref_push(1, 32'hbfc00014, 5, 32'h12345678);
    ev(1, 32'hbfc00014, 4'hf, 0, 32'h12345678);
    ev(0, 32'hbfc00014, 4'hf, 5, 32'h12345678);
    ev(1, 32'hbfc00014, 4'h0, 5, 32'h12345678);
    chk("filter_cnt", cmp_count, 4);
    ev(1, 32'hbfc00014, 4'hf, 5, 32'h12345678);
    chk("filter_cnt2", cmp_count, 5);
    ref_push(1, 32'hbfc00018, 6, 32'haabbccdd);
    ev(1, 32'hbfc00018, 4'hf, 6, 32'h00bbccdd);
    chk("mask_err", {31'd0, err}, 1);
    chk("mask_err_wdata", err_wdata, 32'h00bbccdd);
    chk("mask_err_ref", err_ref_wdata, 32'haabbccdd);
    ev(1, 32'hbfc0001c, 4'hf, 3, 32'h1);
    do_reset();
    cyc(1, 1, 32'hbfc00000, 1, 32'h55, 1, 32'hbfc00000, 4'b0011, 1, 32'h7700aa55);
    chk("uf_flag", {31'd0, underflow}, 1);
    chk("uf_ref", err_ref_wdata, 0);
    chk("uf_wdata", err_wdata, 32'h0000aa55);
    chk("uf_ready", {31'd0, ref_ready}, 0);
    do_reset();
    for (int k = 0; k < D; k++) ref_push(1, fpc(k), fn(k), fd(k));
    chk("full_ready", {31'd0, ref_ready}, 0);
    ev(1, fpc(0), 4'hf, fn(0), fd(0));
    cyc(1, 1, fpc(16), fn(16), fd(16), 1, fpc(1), 4'hf, fn(1), fd(1));
    ref_push(1, fpc(17), fn(17), fd(17));
    chk("refull_ready", {31'd0, ref_ready}, 0);
    for (int k = 2; k < 18; k++) ev(1, fpc(k), 4'hf, fn(k), fd(k));
    chk("drain_cnt", cmp_count, 18);
    ref_push(1, END_PC, 9, 32'hcafef00d);
    ev(1, END_PC, 4'hf, 9, 32'hcafef00d);
    chk("end_done", {31'd0, done}, 1);
    chk("end_cnt", cmp_count, 19);
    ev(1, END_PC, 4'hf, 9, 32'h0);
    chk("end_hold_uf", {31'd0, underflow}, 0);
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
